sig_gen_sweep: RTL and testbench

// - Square-wave test-signal source for the PLL receive path. It drives the PLL's `sig` input from a phase-accumulator DDS.
// - Runs a stepped-frequency sweep: start tone, N increments, programmable dwell per step.
// - Every frequency change is phase-continuous and takes effect only on an accumulator wrap, so no runt pulses are produced.
// - Exports a wrap strobe and the current increment for PLL lock/tracking checks.

---
 rtl/sig_gen_pkg.sv | 12 +
 rtl/sig_gen_phase_acc.sv | 41 ++++
 rtl/sig_gen_sweep.sv | 109 ++++++++++
 tb/tb_sig_gen_sweep.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sig_gen_pkg.sv
// sig_gen_pkg: sweep FSM states, accumulator width, LFSR seed/taps and the clamped increment adder
package sig_gen_pkg;
  localparam int ACC_W_DEF = 32;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {IDLE, RUN, ARMED, DRAIN} state_t;
  function automatic logic [ACC_W_DEF-1:0] sat_add(input logic [ACC_W_DEF-1:0] a, input logic [ACC_W_DEF-1:0] d);
    logic signed [ACC_W_DEF+1:0] s;
    s = $signed({2'b00, a}) + $signed({{2{d[ACC_W_DEF-1]}}, d});
    return s[ACC_W_DEF+1] ? '0 : s[ACC_W_DEF] ? '1 : s[ACC_W_DEF-1:0];
  endfunction
endpackage

// File: rtl/sig_gen_phase_acc.sv
// sig_gen_phase_acc: DDS accumulator (en/clr/incr/duty in; sig/sync/wrap out), LFSR dither when SIG_GEN_DITHER_EN
module sig_gen_phase_acc
  import sig_gen_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
`ifdef SIG_GEN_DITHER_EN
  , parameter int DITHER_W = 12
`endif
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [ACC_W-1:0] incr_i,
  input  logic [7:0]       duty_i,
  output logic             sig_o,
  output logic             sync_o,
  output logic             wrap_o
);
  logic [ACC_W-1:0] acc_q, acc_d, ph;
  logic carry;
  assign {carry, acc_d} = {1'b0, acc_q} + {1'b0, incr_i};
  assign wrap_o = en_i & carry;
`ifdef SIG_GEN_DITHER_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) lfsr_q <= (rst || !en_i) ? LFSR_SEED : {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign ph = acc_q + ACC_W'(lfsr_q[DITHER_W-1:0]);
`else
  assign ph = acc_q;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      acc_q  <= '0;
      sig_o  <= 1'b0;
      sync_o <= 1'b0;
    end else begin
      acc_q  <= clr_i ? '0 : en_i ? acc_d : acc_q;
      sync_o <= wrap_o;
      sig_o  <= en_i && !clr_i && (ph[ACC_W-1 -: 8] < duty_i);
    end
endmodule

// File: rtl/sig_gen_sweep.sv
// sig_gen_sweep: stepped-frequency square-wave DDS with wrap-aligned steps (start/stop/params in; sig/sync/busy/done/step_idx/incr_cur out), dither via SIG_GEN_DITHER_EN
module sig_gen_sweep
  import sig_gen_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int DWELL_W = 24,
  parameter int STEP_W  = 8
`ifdef SIG_GEN_DITHER_EN
  , parameter int DITHER_W = 12
`endif
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [ACC_W-1:0]   f_start,
  input  logic [ACC_W-1:0]   f_step,
  input  logic [STEP_W-1:0]  n_steps,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         duty,
  output logic               sig,
  output logic               sync,
  output logic               busy,
  output logic               done,
  output logic [STEP_W-1:0]  step_idx,
  output logic [ACC_W-1:0]   incr_cur
);
  state_t state_q, state_d;
  logic [ACC_W-1:0] incr_q, incr_d, pend_q, pend_d, f_step_q;
  logic [STEP_W-1:0] step_q, step_d, n_steps_q;
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q;
  logic [7:0] duty_q;
  logic done_q, wrap, adv;
  // a zero increment never wraps, so it must not hold up a step or the drain
  assign adv = wrap || incr_q == '0;
  always_comb begin
    state_d = state_q;
    incr_d  = incr_q;
    pend_d  = pend_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        incr_d  = f_start;
        step_d  = '0;
        cnt_d   = dwell == '0 ? DWELL_W'(1) : dwell;
      end
      RUN: if (stop) state_d = DRAIN;
        else if (cnt_q != DWELL_W'(1)) cnt_d = cnt_q - DWELL_W'(1);
        else if (step_q == n_steps_q) state_d = DRAIN;
        else begin
          pend_d  = sat_add(incr_q, f_step_q);
          state_d = ARMED;
        end
      ARMED: if (stop) state_d = DRAIN;
        else if (adv) begin
          state_d = RUN;
          incr_d  = pend_q;
          step_d  = step_q + STEP_W'(1);
          cnt_d   = dwell_q;
        end
      default: if (adv) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      incr_q  <= '0;
      pend_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      incr_q  <= incr_d;
      pend_q  <= pend_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      done_q  <= state_q != IDLE && state_d == IDLE;
    end
  always_ff @(posedge clk)
    if (state_q == IDLE && start) begin
      f_step_q  <= f_step;
      n_steps_q <= n_steps;
      dwell_q   <= cnt_d;
      duty_q    <= duty;
    end
  sig_gen_phase_acc #(
    .ACC_W(ACC_W)
`ifdef SIG_GEN_DITHER_EN
    , .DITHER_W(DITHER_W)
`endif
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q != IDLE),
    .clr_i  (state_d == IDLE),
    .incr_i (incr_q),
    .duty_i (duty_q),
    .sig_o  (sig),
    .sync_o (sync),
    .wrap_o (wrap)
  );
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign step_idx = step_q;
  assign incr_cur = incr_q;
endmodule

// File: tb/tb_sig_gen_sweep.sv
// tb_sig_gen_sweep: vector table, corner sequences and random sweeps checked cycle by cycle against a behavioural model
module tb_sig_gen_sweep;
  localparam longint TWO32 = 64'h1_0000_0000;
  logic clk = 0, rst = 1, start = 0, stop = 0;
  logic [31:0] f_start = 0, f_step = 0;
  logic [7:0] n_steps = 0, duty = 0;
  logic [23:0] dwell = 0;
  logic sig, sync, busy, done;
  logic [7:0] step_idx;
  logic [31:0] incr_cur;
  int n_tests = 0, n_fail = 0, n_sync = 0, n_high = 0;
  bit seen;
  bit m_busy, m_sig, m_sync, m_done, m_armed, m_drain;
  longint m_phase, m_incr, m_pend, p_step;
  int m_idx, m_left, p_n, p_dwell, p_duty;
  typedef struct {
    logic [31:0] fs, fd;
    int n, dw, dt, e_step;
    logic [31:0] e_incr;
    int e_sync, e_high;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  sig_gen_sweep dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .f_start(f_start), .f_step(f_step),
    .n_steps(n_steps), .dwell(dwell), .duty(duty), .sig(sig), .sync(sync), .busy(busy),
    .done(done), .step_idx(step_idx), .incr_cur(incr_cur)
  );

  function automatic longint clamp(input longint v);
    return v < 0 ? 64'd0 : v >= TWO32 ? TWO32 - 1 : v;
  endfunction

  task automatic model_step();
    longint sum;
    bit wrap, nsig;
    if (rst) begin
      {m_busy, m_sig, m_sync, m_done, m_armed, m_drain} = '0;
      m_phase = 0; m_incr = 0; m_idx = 0; m_left = 0;
      return;
    end
    m_done = 0;
    if (!m_busy) begin
      m_sig = 0; m_sync = 0;
      if (start) begin
        m_busy = 1; m_armed = 0; m_drain = 0;
        m_incr = f_start; m_idx = 0; m_left = dwell == 0 ? 1 : int'(dwell);
        p_step = longint'($signed(f_step)); p_n = n_steps; p_dwell = m_left; p_duty = duty;
      end
      return;
    end
    sum = m_phase + m_incr;
    wrap = sum >= TWO32;
    nsig = (m_phase >> 24) < p_duty;
    m_phase = sum % TWO32;
    m_sync = wrap;
    if (m_drain) begin
      if (wrap || m_incr == 0) begin m_busy = 0; m_done = 1; m_phase = 0; nsig = 0; end
    end else if (stop) begin
      m_drain = 1; m_armed = 0;
    end else if (m_armed) begin
      if (wrap || m_incr == 0) begin m_incr = m_pend; m_idx++; m_left = p_dwell; m_armed = 0; end
    end else if (m_left > 1) m_left--;
    else if (m_idx == p_n) m_drain = 1;
    else begin m_pend = clamp(m_incr + p_step); m_armed = 1; end
    m_sig = nsig;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("cycle", {sig, sync, busy, done, step_idx, incr_cur},
          {m_sig, m_sync, m_busy, m_done, 8'(m_idx), 32'(m_incr)});
    n_sync += int'(sync);
    n_high += int'(sig);
  endtask

  task automatic wait_done(input int lim, output bit s);
    s = 0;
    for (int k = 0; k < lim && !s; k++) begin cyc(); s = done; end
  endtask

  task automatic launch(input logic [31:0] fs, input logic [31:0] fd, input int n, input int dw, input int dt);
    f_start = fs; f_step = fd; n_steps = 8'(n); dwell = 24'(dw); duty = 8'(dt);
    n_sync = 0; n_high = 0;
    start = 1; cyc(); start = 0;
  endtask

  initial begin
    vecs[0] = '{32'd8589934, 32'd0, 0, 5200, 128, 0, 32'd8589934, 11, -1};
    vecs[1] = '{32'd8589934, 32'd8589934, 3, 2000, 128, 3, 32'd34359736, -1, -1};
    vecs[2] = '{32'h4000_0000, 32'h8000_0000, 2, 10, 128, 2, 32'd0, 3, -1};
    vecs[3] = '{32'hFFFF_FF9C, 32'd1000, 1, 3, 128, 1, 32'hFFFF_FFFF, 7, -1};
    vecs[4] = '{32'h2000_0000, 32'd0, 0, 20, 0, 0, 32'h2000_0000, 3, 0};
    vecs[5] = '{32'h0100_0000, 32'd0, 0, 512, 255, 0, 32'h0100_0000, 3, 765};
    vecs[6] = '{32'h4000_0000, 32'd0, 0, 0, 128, 0, 32'h4000_0000, 1, 2};
    cyc(); cyc();
    check("reset", {sig, sync, busy, done, step_idx, incr_cur}, 64'd0);
    rst = 0;
    cyc();
    foreach (vecs[i]) begin
      launch(vecs[i].fs, vecs[i].fd, vecs[i].n, vecs[i].dw, vecs[i].dt);
      wait_done(20000, seen);
      check($sformatf("v%0d_done", i), 64'(seen), 64'd1);
      check($sformatf("v%0d_step", i), 64'(step_idx), 64'(vecs[i].e_step));
      check($sformatf("v%0d_incr", i), 64'(incr_cur), 64'(vecs[i].e_incr));
      if (vecs[i].e_sync >= 0) check($sformatf("v%0d_syncs", i), 64'(n_sync), 64'(vecs[i].e_sync));
      if (vecs[i].e_high >= 0) check($sformatf("v%0d_high", i), 64'(n_high), 64'(vecs[i].e_high));
      cyc(); cyc();
    end
    launch(32'd8589934, 32'd0, 0, 100000, 128);
    repeat (699) cyc();
    stop = 1; cyc(); stop = 0;
    wait_done(2000, seen);
    check("stop_done", 64'(seen), 64'd1);
    check("stop_syncs", 64'(n_sync), 64'd2);
    cyc();
    check("stop_idle", {sig, busy}, 64'd0);
    f_start = 32'h4000_0000; n_steps = 0; dwell = 50; duty = 128;
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    check("start_wins", 64'(busy), 64'd1);
    stop = 1; cyc(); stop = 0;
    wait_done(100, seen);
    check("start_wins_done", 64'(seen), 64'd1);
    launch(32'd8589934, 32'd8589934, 3, 2000, 128);
    repeat (2999) cyc();
    check("mid_step", {step_idx, incr_cur}, {8'd1, 32'd17179868});
    f_start = 32'd123; start = 1; cyc(); start = 0;
    check("busy_start_ignored", {busy, step_idx, incr_cur}, {1'b1, 8'd1, 32'd17179868});
    rst = 1; cyc(); rst = 0;
    check("mid_rst", {sig, sync, busy, done, step_idx, incr_cur}, 64'd0);
    cyc();
    for (int r = 0; r < 8; r++) begin
      launch({8'($urandom_range(1, 255)), 24'd0}, {8'($urandom_range(0, 255)), 24'd0},
             $urandom_range(0, 4), $urandom_range(0, 300), $urandom_range(0, 255));
      seen = 0;
      for (int k = 0; k < 20000 && !seen; k++) begin
        stop = $urandom_range(0, 299) == 0;
        start = $urandom_range(0, 99) == 0;
        if (start) f_start = {8'($urandom_range(1, 255)), 24'd0};
        cyc();
        seen = done;
      end
      start = 0; stop = 0;
      check($sformatf("rnd%0d_done", r), 64'(seen), 64'd1);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
